// File: rtl/core_wb_pkg.sv
// Shared types and constants for the core-to-Wishbone data-port bridge.
package core_wb_pkg;

  // Bridge FSM: wait for a request, run one bus cycle, report completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wbm_state_t;

  // The core only issues full-word accesses, so every byte lane is enabled.
  localparam logic [3:0]  WB_SEL_ALL = 4'hF;

  // Load data handed back to the core when a read ends on error or timeout.
  localparam logic [31:0] ERR_RDATA  = '0;

endpackage

// File: rtl/core_wb_master_wb_watchdog.sv
// Saturating 8-bit cycle counter that flags when a bus cycle has waited
// TIMEOUT cycles without a slave response.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_reg;

  // Count waiting cycles; hold at 8'hFF instead of wrapping back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != 8'hFF)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expired = (count_reg == 8'(TIMEOUT));

endmodule

// File: rtl/core_wb_master.sv
// Bridges the multicycle core's data-memory port onto a Wishbone B4 classic
// bus: one request in, exactly one bus cycle out, with the core stalled
// until the slave acks, errors, or the watchdog gives up.
module core_wb_master
  import core_wb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_select,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              mem_ready,
  output logic              bus_error,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  wbm_state_t state_reg;
  logic       request;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;
  logic       abort;

  assign request = core_select & (MemRead | MemWrite);

  // Count only BUS cycles that end without a response; restart while idle.
  assign wd_clear  = (state_reg == IDLE);
  assign wd_enable = (state_reg == BUS) & ~wb_ack_i & ~wb_err_i;

  // A watchdog expiry is treated exactly like a slave error, and an error
  // takes priority over a simultaneous ack.
  assign abort = wb_err_i | wd_expired;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Main FSM and all registered outputs; completion flags are one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ReadData  <= '0;
      mem_ready <= 1'b0;
      bus_error <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
    end else begin
      mem_ready <= 1'b0;
      bus_error <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (request) begin
            // Address passes through unaligned; a write wins over a read.
            wb_adr_o  <= DataAdr;
            wb_dat_o  <= WriteData;
            wb_we_o   <= MemWrite;
            wb_sel_o  <= WB_SEL_ALL;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            state_reg <= BUS;
          end
        end
        BUS: begin
          // Address/data stay frozen; dropping core_select does not abort.
          if (abort) begin
            if (!wb_we_o) begin
              ReadData <= DATA_W'(ERR_RDATA);
            end
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            mem_ready <= 1'b1;
            bus_error <= 1'b1;
            state_reg <= DONE;
          end else if (wb_ack_i) begin
            if (!wb_we_o) begin
              ReadData <= wb_dat_i;
            end
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            mem_ready <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // The core advances on mem_ready, so a request still visible here
          // is stale and must not start another cycle.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
